// File: rtl/tile_to_raster_if.sv
// rtl/tile_to_raster_if.sv - tile-in / raster-out handshake bundle for tile_to_raster
//
// Purpose : groups the tile input stream and the pixel output stream.
// Signals : i_tile        m*m*8  tile, pixel (r,c) at [((m-1-r)*m*8 + (m-1-c)*8) +: 8]
//           i_tile_valid  1      i_tile holds a valid tile
//           o_tile_ready  1      block accepts a tile this cycle
//           o_data        8      raster-order output pixel
//           o_data_valid  1      o_data valid
//           i_data_ready  1      downstream accepts o_data this cycle
//           o_row_last    1      o_data is column W-1
//           o_band_last   1      o_data is the last pixel of the m-row band
// Modports: master = tile producer / pixel consumer, slave = tile_to_raster.
interface tile_to_raster_if #(
  parameter int m = 2
);
  logic [m*m*8-1:0] i_tile;
  logic             i_tile_valid;
  logic             o_tile_ready;
  logic [7:0]       o_data;
  logic             o_data_valid;
  logic             i_data_ready;
  logic             o_row_last;
  logic             o_band_last;

  modport master (
    output i_tile, i_tile_valid, i_data_ready,
    input  o_tile_ready, o_data, o_data_valid, o_row_last, o_band_last
  );

  modport slave (
    input  i_tile, i_tile_valid, i_data_ready,
    output o_tile_ready, o_data, o_data_valid, o_row_last, o_band_last
  );
endinterface

// File: rtl/tile_to_raster.sv
// rtl/tile_to_raster.sv - m x m tile stream to raster-order pixel stream converter
//
// Purpose : collects W/m tiles of an m-row band into one of two ping-pong
//           banks, then streams the band out row-major, one pixel per cycle.
// Ports   : i_clk  single clock, rising edge
//           i_rst  synchronous active-high reset of control state
//           bus    tile_to_raster_if slave (tile in, pixel out, row/band last)
module tile_to_raster #(
  parameter int W = 512,
  parameter int m = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  tile_to_raster_if.slave bus
);
  localparam int NT   = W / m;
  localparam int WC_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int RC_W = (W > 1) ? $clog2(W) : 1;
  localparam int RR_W = (m > 1) ? $clog2(m) : 1;

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(NT - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(W - 1);
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(m - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [WC_W-1:0] wr_col_q, wr_col_d;
  logic [RC_W-1:0] rd_col_q, rd_col_d;
  logic [RR_W-1:0] rd_row_q, rd_row_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  // Pixel storage; contents are never reset, only the FULL flags gate use.
  logic [7:0] bank_mem [2][m][W];

  logic            tile_ready;
  logic            tile_acc;
  logic            pix_hs;
  logic            col_last;
  logic            row_last;
  logic [RC_W-1:0] nxt_col;
  logic [RR_W-1:0] nxt_row;

  assign tile_ready = !i_rst && !full_q[wr_bank_q];
  assign tile_acc   = bus.i_tile_valid && tile_ready;
  assign pix_hs     = valid_q && bus.i_data_ready;
  assign col_last   = (rd_col_q == RC_LAST);
  assign row_last   = (rd_row_q == RR_LAST);

  // rd_row/rd_col address the pixel currently presented; the next pixel is
  // fetched one address ahead so a handshake can be followed immediately.
  always_comb begin
    nxt_col = rd_col_q + RC_W'(1);
    nxt_row = rd_row_q;
    if (col_last) begin
      nxt_col = '0;
      nxt_row = rd_row_q + RR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_col_d  = wr_col_q;
    rd_col_d  = rd_col_q;
    rd_row_d  = rd_row_q;
    data_d    = data_q;
    valid_d   = valid_q;

    if (tile_acc) begin
      if (wr_col_q == WC_LAST) begin
        wr_col_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + WC_W'(1);
      end
    end

    // The write side only ever touches an EMPTY bank and the read side only a
    // FULL one, so the set above and the clear below never hit the same bit.
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (full_q[rd_bank_q]) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!valid_q) begin
          data_d  = bank_mem[rd_bank_q][rd_row_q][rd_col_q];
          valid_d = 1'b1;
        end else if (pix_hs) begin
          if (col_last && row_last) begin
            state_d           = IDLE;
            valid_d           = 1'b0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_col_d          = '0;
            rd_row_d          = '0;
          end else begin
            rd_col_d = nxt_col;
            rd_row_d = nxt_row;
            data_d   = bank_mem[rd_bank_q][nxt_row][nxt_col];
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_col_q  <= '0;
      rd_col_q  <= '0;
      rd_row_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
      rd_row_q  <= rd_row_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tile_acc) begin
      for (int r = 0; r < m; r++) begin
        for (int c = 0; c < m; c++) begin
          bank_mem[wr_bank_q][RR_W'(r)][RC_W'(int'(wr_col_q) * m + c)] <=
            bus.i_tile[((m-1-r)*m*8 + (m-1-c)*8) +: 8];
        end
      end
    end
  end

  assign bus.o_tile_ready = tile_ready;
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_row_last   = valid_q && col_last;
  assign bus.o_band_last  = valid_q && col_last && row_last;
endmodule

// File: tb/tb_tile_to_raster.sv
// tb/tb_tile_to_raster.sv - scoreboard bench for tile_to_raster (W=8, m=2)
module tb_tile_to_raster;
  localparam int W = 8;
  localparam int M = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       rl;
    logic       bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_to_raster_if #(.m(M)) bus ();

  tile_to_raster #(.W(W), .m(M)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_hs_cyc = -100;
  int   band_start_cyc = -100;
  int   rdy_mode = 0;
  logic rdy_val = 1'b1;

  exp_t       exp_q[$];
  logic [7:0] log_q[$];
  logic [7:0] part [M][W];
  int         part_cols = 0;

  logic       hold_pending = 1'b0;
  exp_t       held;
  logic       in_band = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: assemble the band as a 2-D picture, emit it row-major.
  task automatic model_accept(input logic [M*M*8-1:0] t);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        part[r][part_cols*M + c] = t[((M-1-r)*M*8 + (M-1-c)*8) +: 8];
    part_cols++;
    if (part_cols == W / M) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < W; c++)
          exp_q.push_back('{d: part[r][c], rl: (c == W-1), bl: (c == W-1 && r == M-1)});
      part_cols = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_cols = 0;
  endtask

  task automatic send_tile(input logic [M*M*8-1:0] t);
    int n = 0;
    bus.i_tile       = t;
    bus.i_tile_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.o_tile_ready) break;
      n++;
      if (n > 1000) begin
        chk("tile_accept_timeout", 32'd0, 32'd1);
        bus.i_tile_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    model_accept(t);
    bus.i_tile_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat_tile(input int k);
    return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
  endfunction

  task automatic check_log32(input string name);
    int ref32 [16] = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3, 6, 7, 10, 11, 14, 15};
    chk({name, "_count"}, log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      chk(name, 32'(log_q[i]), 32'(ref32[i]));
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.i_data_ready = rdy_val;
      1:       bus.i_data_ready = ~bus.i_data_ready;
      default: bus.i_data_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares presented pixels against the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      in_band      = 1'b0;
    end else if (bus.o_data_valid) begin
      exp_t cur;
      cur = '{d: bus.o_data, rl: bus.o_row_last, bl: bus.o_band_last};
      if (hold_pending) chk("stall_stable", 32'(cur), 32'(held));
      if (!in_band) begin
        band_start_cyc = cyc;
        in_band        = 1'b1;
      end
      if (bus.i_data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(cur), 32'h3ff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pixel", 32'(cur), 32'(e));
        end
        log_q.push_back(bus.o_data);
        if (bus.o_band_last) begin
          last_hs_cyc = cyc + 1;
          in_band     = 1'b0;
        end
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held         = cur;
      end
    end else begin
      if (hold_pending) chk("valid_dropped_in_stall", 32'd0, 32'd1);
      hold_pending = 1'b0;
      if (bus.o_row_last || bus.o_band_last)
        chk("flags_idle", {30'd0, bus.o_row_last, bus.o_band_last}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    rst              = 1'b1;
    bus.i_tile       = '0;
    bus.i_tile_valid = 1'b0;
    bus.i_data_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", bus.o_data_valid, 0);
    chk("reset_tile_ready", bus.o_tile_ready, 0);
    chk("reset_data", bus.o_data, 0);
    chk("reset_flags", {bus.o_row_last, bus.o_band_last}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.o_tile_ready, 1);
    @(posedge clk);
    #1;

    // Basic band, ready high, with latency check.
    log_q.delete();
    for (int k = 0; k < 4; k++) send_tile(pat_tile(k));
    a = acc_cyc;
    drain();
    chk("first_pixel_latency", band_start_cyc - a, 2);
    check_log32("order_ready_high");

    // Toggling ready.
    rdy_mode = 1;
    log_q.delete();
    for (int k = 0; k < 4; k++) send_tile(pat_tile(k));
    drain();
    check_log32("order_ready_toggle");
    rdy_mode = 0;

    // Both banks fill with ready low; ninth tile must wait for the drain.
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) send_tile(32'($urandom));
    @(negedge clk);
    chk("tile_ready_both_full", bus.o_tile_ready, 0);
    @(posedge clk);
    #1;
    fork
      send_tile(32'($urandom));
      begin
        repeat (5) @(posedge clk);
        #1 rdy_val = 1'b1;
      end
    join
    chk("ready_after_free", acc_cyc - last_hs_cyc, 1);
    for (int k = 0; k < 3; k++) send_tile(32'($urandom));
    drain();

    // Last tile of band 1 accepted on the same edge as band 0's last pixel.
    for (int k = 0; k < 4; k++) send_tile(32'($urandom));
    a = acc_cyc;
    for (int k = 0; k < 3; k++) send_tile(32'($urandom));
    while (cyc < a + 17) begin
      @(posedge clk);
      #1;
    end
    send_tile(32'($urandom));
    chk("simultaneous_edge", acc_cyc, last_hs_cyc);
    drain();
    chk("next_band_within_2", (band_start_cyc - acc_cyc >= 1) && (band_start_cyc - acc_cyc <= 2), 1);

    // Random tiles, random gaps, random back-pressure.
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_tile(32'($urandom));
    end
    drain();
    rdy_mode = 0;
    rdy_val  = 1'b1;

    // Reset mid-write and mid-read; only fresh bands may appear.
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        for (int k = 0; k < 2; k++) send_tile(32'($urandom));
      end else begin
        for (int k = 0; k < 4; k++) send_tile(32'($urandom));
        repeat (6) @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("mid_reset_valid", bus.o_data_valid, 0);
      chk("mid_reset_tile_ready", bus.o_tile_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_reset", bus.o_tile_ready, 1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) send_tile(32'($urandom));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tile_to_raster.md
TILE_TO_RASTER -- requirements
Module: tile_to_raster

Interface
REQ-001 Parameter W, default 512: image row width in pixels.
REQ-002 Parameter m, default 2: output tile edge (m x m bytes per tile); W SHALL be a multiple of m.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_tile  in  m*m*8  tile; pixel (r,c) at bits [((m-1-r)*m*8 + (m-1-c)*8) +: 8].
REQ-006 i_tile_valid  in  1  i_tile holds a valid tile.
REQ-007 o_tile_ready  out  1  block accepts a tile this cycle.
REQ-008 o_data  out  8  raster-order output pixel.
REQ-009 o_data_valid  out  1  o_data valid.
REQ-010 i_data_ready  in  1  downstream accepts o_data this cycle.
REQ-011 o_row_last  out  1  o_data is the last pixel of a row (column W-1).
REQ-012 o_band_last  out  1  o_data is the last pixel of an m-row band.

Function
REQ-013 Storage: two banks (ping-pong), each m rows x W bytes; each bank is EMPTY or FULL.
REQ-014 Tile accept = i_tile_valid && o_tile_ready at a rising edge; the tile is written into the current write bank at columns [wr_col*m, wr_col*m+m-1], rows 0..m-1.
REQ-015 wr_col counts 0..W/m-1 and advances by 1 per accepted tile; wrap from W/m-1 to 0 marks the write bank FULL and toggles the write-bank pointer on the same edge.
REQ-016 o_tile_ready = 1 iff the current write bank is EMPTY and i_rst is low; i_tile_valid without o_tile_ready SHALL have no effect.
REQ-017 Read FSM states: IDLE, STREAM. IDLE -> STREAM when the read bank is FULL; STREAM -> IDLE after the handshake on the band's last pixel.
REQ-018 In STREAM, pixels are emitted row-major: row 0 col 0..W-1, then row 1, ..., row m-1; exactly m*W pixels per band.
REQ-019 Output handshake = o_data_valid && i_data_ready; the read pointer advances only on handshake.
REQ-020 While o_data_valid=1 and i_data_ready=0, o_data, o_row_last and o_band_last SHALL hold stable.
REQ-021 Latency: first pixel of a band SHALL be valid on the 2nd rising edge after the edge accepting that band's last tile (1 cycle IDLE->STREAM, 1 cycle registered read), with i_data_ready held high.
REQ-022 Throughput: with i_data_ready held high, one pixel per cycle for the whole band, no bubbles within a band.
REQ-023 On the last-pixel handshake the read bank becomes EMPTY and the read-bank pointer toggles; if the other bank is already FULL, the next band's first pixel SHALL be valid within 2 cycles.
REQ-024 Simultaneous: last-tile accept into one bank and last-pixel handshake from the other in the same cycle SHALL both take effect; no tile or pixel is lost or duplicated.
REQ-025 When both banks are FULL, o_tile_ready=0 until the read bank empties; o_tile_ready rises the cycle after the freeing handshake.
REQ-026 o_row_last=1 iff read column = W-1; o_band_last=1 iff read column = W-1 and read row = m-1; both are 0 whenever o_data_valid=0.
REQ-027 Counter widths: wr_col $clog2(W/m), rd_col $clog2(W), rd_row $clog2(m) (minimum 1 bit each).

Reset
REQ-028 While i_rst is high at an edge: both banks EMPTY, both bank pointers 0, wr_col/rd_col/rd_row 0, FSM IDLE.
REQ-029 Reset output values: o_data=0, o_data_valid=0, o_row_last=0, o_band_last=0, o_tile_ready=0 while i_rst high, 1 the first cycle after release.
REQ-030 Reset mid-band (write or read) discards all buffered data; no pixel from before reset SHALL appear after it.
REQ-031 Bank contents need no reset; only control state is reset.

Verification (W=8, m=2)
REQ-032 4 tiles, tile k = {r0c0=4k,r0c1=4k+1,r1c0=4k+2,r1c1=4k+3}, ready high -> 16 pixels 0,1,4,5,8,9,12,13,2,3,6,7,10,11,14,15; o_row_last on 13 and 15, o_band_last on 15 only.
REQ-033 8 back-to-back tiles, i_data_ready low -> o_tile_ready falls after 8th accept; 9th tile stalls until 16 pixels of band 0 drained; o_tile_ready returns next cycle.
REQ-034 Band streaming, i_data_ready toggled 1,0,1,0 -> o_data stable while not ready; sequence identical to REQ-032, no drops or repeats.
REQ-035 Last tile of band 1 accepted in the same cycle as pixel 15 of band 0 handshakes -> band 1 first pixel valid within 2 cycles, 32 pixels total correct.
REQ-036 i_rst pulsed after 2 tiles of a band, then 4 fresh tiles -> output contains only the fresh band; o_data_valid=0 and o_tile_ready=0 during reset.
REQ-037 Latency check: ready high, 4 tiles -> first o_data_valid exactly 2 edges after 4th accept.
